// File: rtl/axis_headerizer_arb.sv
// Packet-granular round-robin arbiter in front of axis_headerizer.
// One source at a time is granted and keeps the grant until its TLAST flit
// is accepted. The granted stream is muxed onto the sides_* bus, and TID
// carries the source index so the emitted header names the originator.
module axis_headerizer_arb #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int USER_WIDTH = 8,
    localparam int GW        = (N > 1) ? $clog2(N) : 1,
    localparam int KW        = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N*DATA_WIDTH-1:0]   src_TDATA,
    input  logic [N*KW-1:0]           src_TKEEP,
    input  logic [N-1:0]              src_TLAST,
    input  logic [N-1:0]              src_TVALID,
    output logic [N-1:0]              src_TREADY,
    input  logic [N*DEST_WIDTH-1:0]   src_TDEST,
    input  logic [N*USER_WIDTH-1:0]   src_TUSER,
    input  logic [N-1:0]              arb_mask,
    output logic [DATA_WIDTH-1:0]     sides_TDATA,
    output logic [KW-1:0]             sides_TKEEP,
    output logic                      sides_TLAST,
    output logic [DEST_WIDTH-1:0]     sides_TDEST,
    output logic [USER_WIDTH-1:0]     sides_TUSER,
    output logic [ID_WIDTH-1:0]       sides_TID,
    output logic                      sides_TVALID,
    input  logic                      sides_TREADY,
    output logic                      busy,
    output logic [GW-1:0]             grant_idx
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] next_idx;
    logic [GW-1:0] cand;
    logic          found;
    logic [N-1:0]  eligible;
    logic          flit;

    assign eligible = src_TVALID & arb_mask;

    // Round-robin pick: first eligible source after last_grant, wrapping at N.
    always_comb begin
        next_idx = grant_idx;
        cand     = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = GW'((int'(last_grant) + k) % N);
            if (!found && eligible[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    // Payload mux from the granted source; valid/ready only pass while locked.
    always_comb begin
        sides_TDATA  = src_TDATA[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        sides_TKEEP  = src_TKEEP[grant_idx*KW +: KW];
        sides_TLAST  = src_TLAST[grant_idx];
        sides_TDEST  = src_TDEST[grant_idx*DEST_WIDTH +: DEST_WIDTH];
        sides_TUSER  = src_TUSER[grant_idx*USER_WIDTH +: USER_WIDTH];
        sides_TID    = ID_WIDTH'(grant_idx);
        sides_TVALID = busy & src_TVALID[grant_idx];
        src_TREADY   = '0;
        if (busy) begin
            src_TREADY[grant_idx] = sides_TREADY;
        end
    end

    assign flit = sides_TVALID & sides_TREADY;

    // Grant FSM: IDLE picks a source, LOCKED holds it until the TLAST flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            grant_idx  <= '0;
            last_grant <= GW'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx <= next_idx;
                        busy      <= 1'b1;
                        state     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (flit && sides_TLAST) begin
                        last_grant <= grant_idx;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_headerizer_arb.sv
// Testbench for axis_headerizer_arb: cycle tables, directed corner cases,
// and a randomized run against a packet-level round-robin model.
module tb_axis_headerizer_arb;

    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int DSTW = 16;
    localparam int IDW  = 16;
    localparam int UW   = 8;
    localparam int KW   = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   src_TDATA;
    logic [N*KW-1:0]   src_TKEEP;
    logic [N-1:0]      src_TLAST;
    logic [N-1:0]      src_TVALID;
    logic [N-1:0]      src_TREADY;
    logic [N*DSTW-1:0] src_TDEST;
    logic [N*UW-1:0]   src_TUSER;
    logic [N-1:0]      arb_mask;
    logic [DW-1:0]     sides_TDATA;
    logic [KW-1:0]     sides_TKEEP;
    logic              sides_TLAST;
    logic [DSTW-1:0]   sides_TDEST;
    logic [UW-1:0]     sides_TUSER;
    logic [IDW-1:0]    sides_TID;
    logic              sides_TVALID;
    logic              sides_TREADY;
    logic              busy;
    logic [1:0]        grant_idx;

    axis_headerizer_arb #(.N(N), .DATA_WIDTH(DW), .DEST_WIDTH(DSTW),
                          .ID_WIDTH(IDW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .src_TDATA(src_TDATA), .src_TKEEP(src_TKEEP), .src_TLAST(src_TLAST),
        .src_TVALID(src_TVALID), .src_TREADY(src_TREADY),
        .src_TDEST(src_TDEST), .src_TUSER(src_TUSER), .arb_mask(arb_mask),
        .sides_TDATA(sides_TDATA), .sides_TKEEP(sides_TKEEP),
        .sides_TLAST(sides_TLAST), .sides_TDEST(sides_TDEST),
        .sides_TUSER(sides_TUSER), .sides_TID(sides_TID),
        .sides_TVALID(sides_TVALID), .sides_TREADY(sides_TREADY),
        .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]    v, l, m;
    logic            sr;
    logic [DW-1:0]   d   [N];
    logic [DSTW-1:0] dst [N];
    logic [UW-1:0]   usr [N];

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic [N-1:0] m;
        logic         r;
        logic         e_busy;
        logic         e_sv;
        int           e_tid;
        logic [N-1:0] e_srdy;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            src_TDATA[i*DW +: DW]     = d[i];
            src_TKEEP[i*KW +: KW]     = '1;
            src_TDEST[i*DSTW +: DSTW] = dst[i];
            src_TUSER[i*UW +: UW]     = usr[i];
        end
        src_TVALID   = v;
        src_TLAST    = l;
        arb_mask     = m;
        sides_TREADY = sr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        v = '0; l = '0; m = '1; sr = 1'b1;
        for (int i = 0; i < N; i++) begin
            d[i] = '0; dst[i] = '0; usr[i] = '0;
        end
        drive();
        @(negedge clk);
        chk({tag, ".rst_busy"}, busy, 0);
        chk({tag, ".rst_sv"}, sides_TVALID, 0);
        chk({tag, ".rst_srdy"}, src_TREADY, 0);
        chk({tag, ".rst_gidx"}, grant_idx, 0);
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] enc(input int i, input int p, input int f);
        return {16'(i), 16'(p), 16'(f), 16'hC0DE};
    endfunction

    // randomized-run state
    int owner, mlast, model_flits, dut_flits;
    int pkt [N];
    int fl  [N];
    int len [N];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // v, l, m, r, busy, sides_valid, tid, src_ready
        tbl[0]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[1]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 0, 4'h1};
        tbl[2]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[3]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1, 4'h2};
        tbl[4]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[5]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2, 4'h4};
        tbl[6]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[7]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 3, 4'h8};
        tbl[8]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[9]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 0, 4'h1};
        tbl[10] = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[11] = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1, 4'h2};
        tbl[12] = '{4'hF, 4'hF, 4'hB, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[13] = '{4'hF, 4'hF, 4'hB, 1'b1, 1'b1, 1'b1, 3, 4'h8};
        tbl[14] = '{4'hF, 4'hF, 4'hB, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[15] = '{4'hF, 4'h0, 4'hA, 1'b1, 1'b1, 1'b1, 0, 4'h1};
        tbl[16] = '{4'hF, 4'hF, 4'hA, 1'b1, 1'b1, 1'b1, 0, 4'h1};
        tbl[17] = '{4'hF, 4'hF, 4'hA, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[18] = '{4'hF, 4'hF, 4'hA, 1'b0, 1'b1, 1'b1, 1, 4'h0};
        tbl[19] = '{4'hF, 4'hF, 4'hA, 1'b1, 1'b1, 1'b1, 1, 4'h2};
        tbl[20] = '{4'hF, 4'hF, 4'hA, 1'b1, 1'b0, 1'b0, 0, 4'h0};
        tbl[21] = '{4'hF, 4'hF, 4'hA, 1'b1, 1'b1, 1'b1, 3, 4'h8};

        // ---------------- table-driven cycle vectors ----------------
        do_reset("tbl");
        for (int i = 0; i < N; i++) d[i] = 64'hA0 + 64'(i);
        for (int k = 0; k < 22; k++) begin
            v = tbl[k].v; l = tbl[k].l; m = tbl[k].m; sr = tbl[k].r;
            drive();
            @(negedge clk);
            chk($sformatf("tbl%0d.busy", k), busy, tbl[k].e_busy);
            chk($sformatf("tbl%0d.sv", k), sides_TVALID, tbl[k].e_sv);
            chk($sformatf("tbl%0d.srdy", k), src_TREADY, tbl[k].e_srdy);
            if (tbl[k].e_sv) begin
                chk($sformatf("tbl%0d.tid", k), sides_TID, tbl[k].e_tid);
                chk($sformatf("tbl%0d.gidx", k), grant_idx, tbl[k].e_tid);
                chk($sformatf("tbl%0d.data", k), sides_TDATA, 64'hA0 + 64'(tbl[k].e_tid));
            end
            tick();
        end

        // ---------------- src1 three-flit packet ----------------
        do_reset("a");
        v = 4'b0010; d[1] = 64'h10; l = '0;
        drive();
        @(negedge clk);
        chk("a.idle_busy", busy, 0);
        chk("a.idle_sv", sides_TVALID, 0);
        tick();
        for (int f = 0; f < 3; f++) begin
            d[1] = 64'h10 + 64'(f); l[1] = (f == 2);
            drive();
            @(negedge clk);
            chk($sformatf("a.f%0d.sv", f), sides_TVALID, 1);
            chk($sformatf("a.f%0d.busy", f), busy, 1);
            chk($sformatf("a.f%0d.tid", f), sides_TID, 1);
            chk($sformatf("a.f%0d.data", f), sides_TDATA, 64'h10 + 64'(f));
            chk($sformatf("a.f%0d.last", f), sides_TLAST, (f == 2));
            chk($sformatf("a.f%0d.srdy", f), src_TREADY, 4'b0010);
            tick();
        end
        v = '0; drive();
        @(negedge clk);
        chk("a.end_busy", busy, 0);
        chk("a.end_sv", sides_TVALID, 0);
        tick();

        // -------- src2 holds grant while src0 waits; src2 stalls --------
        do_reset("b");
        v = 4'b0100; l = '0; d[2] = 64'h20; d[0] = 64'h0A;
        drive();
        @(negedge clk);
        chk("b.c0_busy", busy, 0);
        tick();
        v = 4'b0101; drive();
        @(negedge clk);
        chk("b.c1_tid", sides_TID, 2);
        chk("b.c1_data", sides_TDATA, 64'h20);
        chk("b.c1_srdy", src_TREADY, 4'b0100);
        tick();
        v = 4'b0001; drive();
        @(negedge clk);
        chk("b.c2_busy", busy, 1);
        chk("b.c2_sv", sides_TVALID, 0);
        chk("b.c2_gidx", grant_idx, 2);
        chk("b.c2_srdy", src_TREADY, 4'b0100);
        tick();
        v = 4'b0101; l = 4'b0100; d[2] = 64'h21; drive();
        @(negedge clk);
        chk("b.c3_tid", sides_TID, 2);
        chk("b.c3_data", sides_TDATA, 64'h21);
        chk("b.c3_last", sides_TLAST, 1);
        tick();
        v = 4'b0001; l = 4'b0001; drive();
        @(negedge clk);
        chk("b.c4_busy", busy, 0);
        tick();
        drive();
        @(negedge clk);
        chk("b.c5_tid", sides_TID, 0);
        chk("b.c5_data", sides_TDATA, 64'h0A);
        chk("b.c5_srdy", src_TREADY, 4'b0001);
        tick();
        v = '0; drive();
        @(negedge clk);
        chk("b.c6_busy", busy, 0);
        tick();

        // -------- src3 four-flit packet with sides_TREADY 1,0,0,1,... --------
        begin
            logic pat [12];
            int nf, cyc;
            pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            do_reset("c");
            v = 4'b1000; l = '0; d[3] = 64'h30;
            drive();
            @(negedge clk);
            chk("c.idle_busy", busy, 0);
            tick();
            nf = 0; cyc = 0;
            while (nf < 4 && cyc < 12) begin
                sr = pat[cyc]; d[3] = 64'h30 + 64'(nf); l[3] = (nf == 3);
                drive();
                @(negedge clk);
                chk($sformatf("c.%0d.srdy", cyc), src_TREADY, {sr, 3'b000});
                chk($sformatf("c.%0d.data", cyc), sides_TDATA, 64'h30 + 64'(nf));
                if (sides_TVALID && sides_TREADY) nf++;
                tick();
                cyc++;
            end
            chk("c.flits", nf, 4);
            chk("c.cycles", cyc, 6);
            sr = 1'b1; v = '0; drive();
            @(negedge clk);
            chk("c.end_busy", busy, 0);
            tick();
        end

        // -------- asynchronous reset mid-packet --------
        do_reset("d");
        v = 4'b0010; l = '0; d[1] = 64'h55;
        drive();
        tick();
        @(negedge clk);
        chk("d.pre_busy", busy, 1);
        chk("d.pre_sv", sides_TVALID, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("d.async_busy", busy, 0);
        chk("d.async_sv", sides_TVALID, 0);
        chk("d.async_srdy", src_TREADY, 0);
        tick();
        v = 4'b0110; l = 4'b0110; d[2] = 64'h66;
        drive();
        rst = 1'b0;
        @(negedge clk);
        chk("d.rel_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("d.first_tid", sides_TID, 1);
        chk("d.first_sv", sides_TVALID, 1);
        chk("d.first_data", sides_TDATA, 64'h55);
        tick();

        // ---------------- randomized run vs. reference model ----------------
        do_reset("r");
        owner = -1; mlast = N - 1; model_flits = 0; dut_flits = 0;
        for (int i = 0; i < N; i++) begin
            pkt[i] = 0; fl[i] = 0; len[i] = $urandom_range(4, 1);
        end
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] e_srdy;
            logic         e_sv, acc;
            if ($urandom_range(15) == 0) m = N'($urandom);
            sr = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!v[i]) v[i] = ($urandom_range(2) == 0);
                d[i]   = enc(i, pkt[i], fl[i]);
                l[i]   = (fl[i] == len[i] - 1);
                dst[i] = DSTW'(i * 3 + pkt[i]);
                usr[i] = UW'(fl[i]);
            end
            drive();
            @(negedge clk);
            e_srdy = '0;
            e_sv   = 1'b0;
            if (owner >= 0) begin
                e_srdy[owner] = sr;
                e_sv = v[owner];
            end
            chk("r.busy", busy, (owner >= 0));
            chk("r.sv", sides_TVALID, e_sv);
            chk("r.srdy", src_TREADY, e_srdy);
            if (e_sv) begin
                chk("r.tid", sides_TID, owner);
                chk("r.data", sides_TDATA, enc(owner, pkt[owner], fl[owner]));
                chk("r.last", sides_TLAST, (fl[owner] == len[owner] - 1));
                chk("r.dest", sides_TDEST, DSTW'(owner * 3 + pkt[owner]));
            end
            acc = e_sv && sr;
            if (sides_TVALID && sides_TREADY) dut_flits++;
            tick();
            if (owner < 0) begin
                bit got;
                got = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int cand;
                    cand = (mlast + k) % N;
                    if (!got && v[cand] && m[cand]) begin
                        got = 1'b1;
                        owner = cand;
                    end
                end
            end else if (acc) begin
                model_flits++;
                v[owner] = 1'b0;
                fl[owner]++;
                if (fl[owner] == len[owner]) begin
                    fl[owner]  = 0;
                    pkt[owner]++;
                    len[owner] = $urandom_range(4, 1);
                    mlast = owner;
                    owner = -1;
                end
            end
        end
        chk("r.flit_count", dut_flits, model_flits);
        chk("r.progress", (model_flits > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_headerizer_arb.md
Name: axis_headerizer_arb

Overview:
- Packet-granular round-robin arbiter that shares one axis_headerizer between N AXI-Stream sources.
- Grants one source at a time and holds the grant until that source's TLAST flit is accepted.
- Muxes the granted source onto the headerizer's "sides" input and stamps TID with the source index, so the emitted header identifies the originator.
- Sits directly upstream of axis_headerizer in the dbg_guv middleware path.

Parameters:
- N, 4, number of requesting streams (2..16).
- DATA_WIDTH, 64, TDATA width; TKEEP is DATA_WIDTH/8.
- DEST_WIDTH, 16, TDEST width (passed through).
- ID_WIDTH, 16, output TID width; must be >= clog2(N).
- USER_WIDTH, 8, TUSER width (passed through).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- src_TDATA  in  N*DATA_WIDTH  source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]; same slicing for all src_ buses.
- src_TKEEP  in  N*DATA_WIDTH/8  per-source keep.
- src_TLAST  in  N  per-source last.
- src_TVALID  in  N  per-source valid.
- src_TREADY  out  N  per-source ready.
- src_TDEST  in  N*DEST_WIDTH  per-source dest.
- src_TUSER  in  N*USER_WIDTH  per-source user.
- arb_mask  in  N  1 = source eligible for new grants.
- sides_TDATA/TKEEP/TLAST/TDEST/TUSER  out  matching widths  muxed from granted source.
- sides_TID  out  ID_WIDTH  granted index, zero-extended.
- sides_TVALID  out  1  output valid.
- sides_TREADY  in  1  headerizer ready.
- busy  out  1  high in LOCKED.
- grant_idx  out  clog2(N)  current/last granted index.

Behaviour:
- Reset (async assert, any state): state=IDLE, grant_idx=0, last_grant=N-1 (source 0 has first priority), busy=0, sides_TVALID=0, all src_TREADY=0. A packet in flight at reset is truncated; no TLAST is emitted for it.
- States: IDLE, LOCKED.
- IDLE:
  - Eligible set = src_TVALID & arb_mask.
  - If non-empty, register grant_idx = first eligible index scanning last_grant+1, last_grant+2, ... modulo N (wrap-around), then go to LOCKED.
  - sides_TVALID=0 and all src_TREADY=0 while in IDLE.
- LOCKED:
  - sides_* = slice[grant_idx] (combinational mux); sides_TID = grant_idx.
  - sides_TVALID = src_TVALID[grant_idx]; src_TREADY[grant_idx] = sides_TREADY; all other src_TREADY = 0.
  - Flit = sides_TVALID & sides_TREADY.
  - Flit with sides_TLAST=1: last_grant <= grant_idx, go to IDLE.
- Latency: a request seen in IDLE at edge k presents its first flit combinationally during cycle k+1. Each packet costs exactly one bubble cycle (the IDLE cycle) before the next grant.
- A granted source dropping TVALID mid-packet: grant is held indefinitely, with no timeout and no preemption.
- arb_mask changes affect new grants only; clearing a granted source's mask bit mid-packet does not abort the packet.
- A single-flit packet (TLAST on first flit) gives LOCKED for one cycle, then IDLE.
- sides_TREADY low: grant held, src_TREADY[grant_idx]=0, and the granted source holds its data per AXIS rules.
- grant_idx retains its value in IDLE until the next grant.

Test Plan:
- Only src1 valid with 3-flit packet (TDATA 0x10,0x11,0x12; TLAST on 0x12), sides_TREADY=1 -> after one IDLE cycle, sides_TDATA 0x10,0x11,0x12 on consecutive cycles; sides_TID=1; busy high 3 cycles; then IDLE.
- All four sources valid continuously with 1-flit packets, from reset -> grant order 0,1,2,3,0,1, one packet every 2 cycles; sides_TID follows that order.
- Sources 0 and 2 valid, grant on 2, src0 raises mid-packet -> src0 not granted until 2's TLAST flit; next grant is 0 (wrap from last_grant=2 past 3).
- arb_mask=4'b1011 with all valid -> source 2 is never granted; sequence 0,1,3,0. Clearing mask bit 0 while 0 is granted -> its packet completes.
- sides_TREADY toggled 1,0,0,1 during a 4-flit packet from src3 -> no flit lost or duplicated; src_TREADY[3] mirrors sides_TREADY; all other readies stay 0.
- rst asserted asynchronously mid-packet (between edges) -> sides_TVALID, busy and src_TREADY fall immediately. After release, first grant goes to the lowest-index valid source.
